// File: rtl/sifh_tof_capture.sv
// First-photon time-of-flight capture feeding the SiFH histogram stage.
// Emits one bin code per laser window (all-ones when no photon) with pixel/acq/data indices.
module sifh_tof_capture #(
   parameter int unsigned NP        = 10,
   parameter int unsigned WINDOW    = 1023,
   parameter int unsigned DATA_NUM  = 2,
   parameter int unsigned ACQ_NUM   = 3,
   parameter int unsigned PIXEL_NUM = 4,
   localparam int unsigned DW = (DATA_NUM  > 1) ? $clog2(DATA_NUM)  : 1,
   localparam int unsigned AW = (ACQ_NUM   > 1) ? $clog2(ACQ_NUM)   : 1,
   localparam int unsigned PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
   input  logic          clk,
   input  logic          res,
   input  logic          enable,
   input  logic          laser_sync,
   input  logic          spad_in,
   output logic [NP-1:0] data,
   output logic          wrEn,
   output logic [DW-1:0] data_idx,
   output logic [AW-1:0] acq_idx,
   output logic [PW-1:0] pix_idx,
   output logic          frame_done,
   output logic          busy
);

   localparam logic [NP-1:0] NO_PHOTON = '1;
   localparam logic [NP-1:0] TERM      = NP'(WINDOW - 1);
   localparam logic [DW-1:0] DATA_MAX  = DW'(DATA_NUM - 1);
   localparam logic [AW-1:0] ACQ_MAX   = AW'(ACQ_NUM - 1);
   localparam logic [PW-1:0] PIX_MAX   = PW'(PIXEL_NUM - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

   state_t        state;
   logic [2:0]    sync;
   logic          hit;
   logic [NP-1:0] cnt;
   logic [NP-1:0] cap;
   logic          got;
   logic          close_c;
   logic          last_word_c;

   assign close_c     = (cnt == TERM) || laser_sync;
   assign last_word_c = (data_idx == DATA_MAX) && (acq_idx == ACQ_MAX) && (pix_idx == PIX_MAX);

   // Two-flop synchronizer plus registered rising-edge detect; latency stays in the bin code
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sync <= '0;
         hit  <= 1'b0;
      end else begin
         sync <= {sync[1:0], spad_in};
         hit  <= sync[1] & ~sync[2];
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state      <= S_IDLE;
         cnt        <= '0;
         cap        <= '0;
         got        <= 1'b0;
         data       <= '0;
         wrEn       <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wrEn       <= 1'b0;
         frame_done <= 1'b0;
         unique case (state)
            S_IDLE, S_WAIT: begin
               if (enable && laser_sync) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  got   <= 1'b0;
               end else if (!enable) begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               cnt <= cnt + NP'(1);
               if (hit && !got) begin
                  got <= 1'b1;
                  cap <= cnt;
               end
               // A hit on the closing cycle still counts if nothing was captured yet
               if (close_c) begin
                  wrEn       <= 1'b1;
                  data       <= got ? cap : (hit ? cnt : NO_PHOTON);
                  frame_done <= last_word_c;
                  cnt        <= '0;
                  got        <= 1'b0;
                  if (!enable) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else if (laser_sync) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Indices name the word on data; they step once each strobe has been presented
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         data_idx <= '0;
         acq_idx  <= '0;
         pix_idx  <= '0;
      end else if (wrEn) begin
         if (data_idx == DATA_MAX) begin
            data_idx <= '0;
            if (acq_idx == ACQ_MAX) begin
               acq_idx <= '0;
               pix_idx <= (pix_idx == PIX_MAX) ? '0 : pix_idx + PW'(1);
            end else begin
               acq_idx <= acq_idx + AW'(1);
            end
         end else begin
            data_idx <= data_idx + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sifh_tof_capture.sv
// Directed bench for sifh_tof_capture: photon capture, pile-up, early sync, frame indices, reset.
module tb_sifh_tof_capture;

   logic       clk;
   logic       res;
   logic       enable;
   logic       laser_sync;
   logic       spad_in;
   logic [9:0] data;
   logic       wrEn;
   logic [0:0] data_idx;
   logic [1:0] acq_idx;
   logic [1:0] pix_idx;
   logic       frame_done;
   logic       busy;

   int nvec    = 0;
   int nerr    = 0;
   int pos     = 0;
   int wcnt    = 0;
   int wr_seen = 0;

   sifh_tof_capture dut (
      .clk        (clk),
      .res        (res),
      .enable     (enable),
      .laser_sync (laser_sync),
      .spad_in    (spad_in),
      .data       (data),
      .wrEn       (wrEn),
      .data_idx   (data_idx),
      .acq_idx    (acq_idx),
      .pix_idx    (pix_idx),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // pos counts clock edges since the window-opening edge; the counter equals pos during RUN
   task automatic step();
      @(posedge clk);
      #1;
      pos++;
   endtask

   task automatic go_to(input int e);
      while (pos < e) step();
   endtask

   task automatic open_window();
      laser_sync = 1'b1;
      step();
      laser_sync = 1'b0;
      pos = 0;
   endtask

   // Raising spad_in three edges early lands hit on counter value hit_at
   task automatic pulse_spad(input int hit_at);
      go_to(hit_at - 3);
      spad_in = 1'b1;
      go_to(hit_at - 1);
      spad_in = 1'b0;
   endtask

   task automatic check_word(input string tag, input int expd);
      chk({tag, "_wren"},  32'(wrEn), 32'd1);
      chk({tag, "_data"},  32'(data), 32'(expd));
      chk({tag, "_didx"},  32'(data_idx), 32'(wcnt % 2));
      chk({tag, "_aidx"},  32'(acq_idx), 32'((wcnt / 2) % 3));
      chk({tag, "_pidx"},  32'(pix_idx), 32'((wcnt / 6) % 4));
      chk({tag, "_fdone"}, 32'(frame_done), 32'((wcnt % 24) == 23));
      wcnt++;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data"},  32'(data), 32'd0);
      chk({tag, "_wren"},  32'(wrEn), 32'd0);
      chk({tag, "_didx"},  32'(data_idx), 32'd0);
      chk({tag, "_aidx"},  32'(acq_idx), 32'd0);
      chk({tag, "_pidx"},  32'(pix_idx), 32'd0);
      chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
   endtask

   initial begin
      res        = 1'b0;
      enable     = 1'b0;
      laser_sync = 1'b0;
      spad_in    = 1'b0;
      #1;
      check_reset_outputs("reset");
      step();
      step();
      res    = 1'b1;
      enable = 1'b1;
      step();

      // First photon at counter 108, terminal close
      open_window();
      chk("t1_busy", 32'(busy), 32'd1);
      pulse_spad(108);
      go_to(1022);
      chk("t1_pre_wren", 32'(wrEn), 32'd0);
      go_to(1023);
      check_word("t1", 108);
      go_to(1024);
      chk("t1_post_wren", 32'(wrEn), 32'd0);
      chk("t1_wait_busy", 32'(busy), 32'd0);
      chk("t1_hold_data", 32'(data), 32'd108);

      // No photon: reserved all-ones code
      open_window();
      go_to(1023);
      check_word("t2", 1023);
      go_to(1024);
      chk("t2_post_wren", 32'(wrEn), 32'd0);
      chk("t2_wait_busy", 32'(busy), 32'd0);

      // Pile-up: only the first hit of the window is kept
      open_window();
      pulse_spad(50);
      pulse_spad(300);
      go_to(1023);
      check_word("t3a", 50);
      go_to(1024);

      // Lone hit on the terminal cycle, with a coincident laser_sync reopening the window
      open_window();
      pulse_spad(1022);
      go_to(1022);
      laser_sync = 1'b1;
      go_to(1023);
      laser_sync = 1'b0;
      check_word("t3b", 1022);
      chk("t3b_busy", 32'(busy), 32'd1);
      pos = 0;

      // Early sync close at counter 400, then photon at 30 in the next window
      pulse_spad(200);
      go_to(399);
      laser_sync = 1'b1;
      go_to(400);
      laser_sync = 1'b0;
      check_word("t4a", 200);
      chk("t4a_busy", 32'(busy), 32'd1);
      pos = 0;
      pulse_spad(30);
      go_to(1022);
      chk("t4b_pre_wren", 32'(wrEn), 32'd0);
      go_to(1023);
      check_word("t4b", 30);
      go_to(1024);
      chk("t4b_wait_busy", 32'(busy), 32'd0);

      // Reset in the middle of a window that already captured a hit
      open_window();
      pulse_spad(100);
      go_to(500);
      res = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      wcnt = 0;
      step();
      step();
      res = 1'b1;
      wr_seen = 0;
      for (int i = 0; i < 1100; i++) begin
         step();
         if (wrEn) wr_seen++;
      end
      chk("t5_no_wren", 32'(wr_seen), 32'd0);
      chk("t5_idle_busy", 32'(busy), 32'd0);
      open_window();
      go_to(1023);
      check_word("t5_next", 1023);
      go_to(1024);

      // Frame sequencing over back-to-back short windows; last one closes with enable low
      res = 1'b0;
      step();
      res = 1'b1;
      wcnt = 0;
      open_window();
      for (int w = 0; w < 26; w++) begin
         if (w % 2 == 1) pulse_spad(4);
         if (w == 25) begin
            go_to(4);
            enable = 1'b0;
         end
         go_to(7);
         laser_sync = 1'b1;
         go_to(8);
         laser_sync = 1'b0;
         check_word($sformatf("t6_w%0d", w), (w % 2 == 1) ? 4 : 1023);
         chk($sformatf("t6_w%0d_busy", w), 32'(busy), 32'(w < 25));
         pos = 0;
         go_to(1);
         chk($sformatf("t6_w%0d_wren_off", w), 32'(wrEn), 32'd0);
      end

      // laser_sync while disabled is ignored
      laser_sync = 1'b1;
      step();
      laser_sync = 1'b0;
      step();
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_wren", 32'(wrEn), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
